// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - multi-channel round-robin card dealer with finite shoe
module card_shoe #(
  parameter int NUM_CH   = 2,
  parameter int CARD_MAX = 10,
  parameter int COPIES   = 4,
  parameter int CARD_W   = 5
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CH-1:0]                     draw,
  input  logic                                  shuffle,
  output logic [NUM_CH*CARD_W-1:0]              card_out,
  output logic [NUM_CH-1:0]                     card_valid,
  output logic [$clog2(CARD_MAX*COPIES+1)-1:0]  cards_left,
  output logic                                  deck_empty
);

  localparam int LEFT_W = $clog2(CARD_MAX*COPIES+1);
  localparam int REM_W  = $clog2(COPIES+1);
  localparam int RANK_W = $clog2(CARD_MAX+1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [LEFT_W-1:0] FULL_SHOE = LEFT_W'(CARD_MAX*COPIES);
  localparam logic [RANK_W-1:0] RANK_TOP  = RANK_W'(CARD_MAX);
  localparam logic [REM_W-1:0]  REM_FULL  = REM_W'(COPIES);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t              state_q, state_d;
  logic [RANK_W-1:0]   rank_q;
  logic [RANK_W-1:0]   cand_q, cand_d;
  logic [RANK_W-1:0]   cand_idx;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     idx;
  logic                found;
  logic [NUM_CH-1:0]   draw_q;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   grant_mask;
  logic [NUM_CH-1:0]   card_valid_q;
  logic [LEFT_W-1:0]   cards_left_q, cards_left_d;
  logic [REM_W-1:0]    remaining_q [CARD_MAX];
  logic [CARD_W-1:0]   card_q [NUM_CH];
  logic                deliver;
  logic                dec_en;
  logic [CARD_W-1:0]   deliver_val;

  assign cand_idx   = cand_q - 1'b1;
  assign grant_mask = NUM_CH'(1) << grant_q;

  // Arbitration, rank search and shuffle override
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    deliver     = 1'b0;
    dec_en      = 1'b0;
    deliver_val = '0;
    found       = 1'b0;
    idx         = '0;
    case (state_q)
      IDLE: begin
        for (int j = 0; j < NUM_CH; j++) begin
          idx = CH_W'((int'(rr_ptr_q) + j) % NUM_CH);
          if (!found && pending_q[idx]) begin
            found   = 1'b1;
            grant_d = idx;
          end
        end
        if (found) begin
          cand_d   = rank_q;
          state_d  = SEARCH;
          rr_ptr_d = (int'(grant_d) == NUM_CH-1) ? '0 : grant_d + 1'b1;
        end
      end
      SEARCH: begin
        if (cards_left_q == '0) begin
          deliver = 1'b1;
          state_d = IDLE;
        end else if (remaining_q[cand_idx] != '0) begin
          deliver     = 1'b1;
          dec_en      = 1'b1;
          deliver_val = CARD_W'(cand_q);
          state_d     = IDLE;
        end else begin
          cand_d = (cand_q == RANK_TOP) ? RANK_W'(1) : cand_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A shuffle abandons any grant in flight; its pending bit survives for a re-grant
    if (shuffle) begin
      state_d  = IDLE;
      cand_d   = cand_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      deliver  = 1'b0;
      dec_en   = 1'b0;
    end
  end

  // Pending requests: new rising edges win over the clear of a delivered grant
  always_comb begin
    pending_d = (pending_q & ~(deliver ? grant_mask : '0)) | (draw & ~draw_q);
    if (shuffle)     cards_left_d = FULL_SHOE;
    else if (dec_en) cards_left_d = cards_left_q - 1'b1;
    else             cards_left_d = cards_left_q;
  end

  // Control state, rank counter and per-channel output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rank_q       <= RANK_W'(1);
      cand_q       <= RANK_W'(1);
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      draw_q       <= '0;
      pending_q    <= '0;
      card_valid_q <= '0;
      cards_left_q <= FULL_SHOE;
      for (int i = 0; i < NUM_CH; i++) card_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rank_q       <= (rank_q == RANK_TOP) ? RANK_W'(1) : rank_q + 1'b1;
      cand_q       <= cand_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      draw_q       <= draw;
      pending_q    <= pending_d;
      card_valid_q <= deliver ? grant_mask : '0;
      cards_left_q <= cards_left_d;
      if (deliver) card_q[grant_q] <= deliver_val;
    end
  end

  // Remaining-copies table: refilled on reset or shuffle, decremented per dealt card
  always_ff @(posedge clock) begin
    if (reset || shuffle) begin
      for (int r = 0; r < CARD_MAX; r++) remaining_q[r] <= REM_FULL;
    end else if (dec_en) begin
      remaining_q[cand_idx] <= remaining_q[cand_idx] - 1'b1;
    end
  end

  // Flatten per-channel card registers onto the output bus
  always_comb begin
    card_out = '0;
    for (int i = 0; i < NUM_CH; i++) card_out[i*CARD_W +: CARD_W] = card_q[i];
  end

  assign card_valid = card_valid_q;
  assign cards_left = cards_left_q;
  assign deck_empty = (cards_left_q == '0);

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - self-checking bench for card_shoe
module tb_card_shoe;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] draw = 2'b00;
  logic       shuffle = 1'b0;
  logic [9:0] card_out;
  logic [1:0] card_valid;
  logic [5:0] cards_left;
  logic       deck_empty;

  int checks = 0;
  int errors = 0;

  card_shoe #(.NUM_CH(2), .CARD_MAX(10), .COPIES(4), .CARD_W(5)) dut (
    .clock(clock), .reset(reset), .draw(draw), .shuffle(shuffle),
    .card_out(card_out), .card_valid(card_valid),
    .cards_left(cards_left), .deck_empty(deck_empty)
  );

  always #5 clock = ~clock;

  // Transaction-level model: a grant resolves its card and delivery time at once
  int         m_rank, m_rr, m_g, m_val, m_due, m_left;
  int         m_cnt [1:10];
  bit         m_busy, m_init = 0;
  logic [1:0] m_drawq, m_pend, m_valid, m_clr;
  logic [4:0] m_card [2];

  always @(posedge clock) begin
    if (reset) begin
      m_rank = 1; m_rr = 0; m_busy = 0; m_left = 40; m_drawq = 0; m_pend = 0;
      m_valid = 0; m_card[0] = 0; m_card[1] = 0; m_init = 1; m_g = 0; m_val = 0; m_due = 0;
      for (int r = 1; r <= 10; r++) m_cnt[r] = 4;
    end else begin
      m_valid = 0; m_clr = 0;
      if (shuffle) begin
        for (int r = 1; r <= 10; r++) m_cnt[r] = 4;
        m_left = 40; m_busy = 0;
      end else if (m_busy) begin
        m_due--;
        if (m_due == 0) begin
          m_valid[m_g] = 1'b1;
          m_card[m_g]  = 5'(m_val);
          if (m_val != 0) begin m_cnt[m_val]--; m_left--; end
          m_clr[m_g] = 1'b1;
          m_busy = 0;
        end
      end else if (m_pend != 0) begin
        for (int j = 1; j >= 0; j--) if (m_pend[(m_rr + j) % 2]) m_g = (m_rr + j) % 2;
        m_rr = (m_g + 1) % 2;
        if (m_left == 0) begin
          m_val = 0; m_due = 1;
        end else begin
          m_val = m_rank; m_due = 1;
          while (m_cnt[m_val] == 0) begin m_val = (m_val == 10) ? 1 : m_val + 1; m_due++; end
        end
        m_busy = 1;
      end
      m_pend  = (m_pend & ~m_clr) | (draw & ~m_drawq);
      m_drawq = draw;
      m_rank  = (m_rank == 10) ? 1 : m_rank + 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (m_init) begin
      checks++;
      if (card_valid !== m_valid) begin errors++; $display("FAIL model_valid act=%b exp=%b t=%0t", card_valid, m_valid, $time); end
      checks++;
      if (card_out !== {m_card[1], m_card[0]}) begin errors++; $display("FAIL model_card act=%h exp=%h t=%0t", card_out, {m_card[1], m_card[0]}, $time); end
      checks++;
      if (cards_left !== 6'(m_left)) begin errors++; $display("FAIL model_left act=%0d exp=%0d t=%0t", cards_left, m_left, $time); end
      checks++;
      if (deck_empty !== (m_left == 0)) begin errors++; $display("FAIL model_empty act=%b exp=%b t=%0t", deck_empty, (m_left == 0), $time); end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; draw = 2'b00; shuffle = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  // Return just after the edge at which the rank counter reads target-1
  task automatic align(input int target);
    int prev;
    prev = (target == 1) ? 10 : target - 1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clock); #1;
      if (m_rank == prev) break;
    end
  endtask

  // Pulse a request and measure edges until the channel's valid, plus its card
  task automatic serve(input logic [1:0] mask, input int ch, output int lat, output int val);
    bit got;
    got = 0; lat = 0; val = -1;
    draw = mask;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clock); lat++; #1;
      if (lat == 1) draw = draw & ~mask;
      @(negedge clock);
      if (card_valid[ch]) begin got = 1; val = int'(card_out[ch*5 +: 5]); end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL serve_timeout ch=%0d act=no_valid exp=valid", ch);
    end
  endtask

  task automatic pair(output int f0, output int f1);
    f0 = 0; f1 = 0;
    draw = 2'b11;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (n == 1) draw = 2'b00;
      @(negedge clock);
      if (card_valid[0] && f0 == 0) f0 = n;
      if (card_valid[1] && f1 == 0) f1 = n;
    end
  endtask

  int lat, val, f0, f1, cnt;
  int tally [0:10];

  initial begin
    // Reset values
    do_reset();
    chk("rst_card_out", int'(card_out), 0);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_left", int'(cards_left), 40);
    chk("rst_empty", int'(deck_empty), 0);

    // Single draw capturing rank 7
    align(7);
    serve(2'b01, 0, lat, val);
    chk("d7_val", val, 7);
    chk("d7_lat", lat, 3);
    chk("d7_validvec", int'(card_valid), 1);
    chk("d7_left", int'(cards_left), 39);
    @(negedge clock);
    chk("d7_pulse_width", int'(card_valid), 0);

    // Five draws at rank 3: the fifth skips to rank 4 one cycle later
    for (int i = 1; i <= 5; i++) begin
      align(3);
      serve(2'b01, 0, lat, val);
      chk("r3_val", val, (i <= 4) ? 3 : 4);
      chk("r3_lat", lat, (i <= 4) ? 3 : 4);
    end
    chk("r3_left", int'(cards_left), 34);

    // Simultaneous draws and round-robin order
    do_reset();
    pair(f0, f1);
    chk("rr1_ch0", f0, 3);
    chk("rr1_ch1", f1, 5);
    serve(2'b01, 0, lat, val);
    chk("rr_single_lat", lat, 3);
    pair(f0, f1);
    chk("rr2_ch1", f1, 3);
    chk("rr2_ch0", f0, 5);

    // Exhaust the shoe
    do_reset();
    for (int r = 0; r <= 10; r++) tally[r] = 0;
    for (int i = 0; i < 40; i++) begin
      align((i * 7) % 10 + 1);
      serve(2'b01, 0, lat, val);
      if (val >= 0 && val <= 10) tally[val]++;
      if (i == 38) chk("empty_at_39", int'(deck_empty), 0);
      if (i == 39) begin
        chk("empty_at_40", int'(deck_empty), 1);
        chk("left_at_40", int'(cards_left), 0);
      end
    end
    for (int r = 1; r <= 10; r++) chk("rank_tally", tally[r], 4);
    serve(2'b01, 0, lat, val);
    chk("draw41_val", val, 0);
    chk("draw41_lat", lat, 3);
    @(posedge clock); #1 shuffle = 1'b1;
    @(posedge clock); #1 shuffle = 1'b0;
    @(negedge clock);
    chk("shuf_left", int'(cards_left), 40);
    chk("shuf_empty", int'(deck_empty), 0);

    // Shuffle during SEARCH aborts and the request is re-granted
    do_reset();
    draw = 2'b01;
    @(posedge clock); #1 draw = 2'b00;
    @(posedge clock); #1 shuffle = 1'b1;
    @(posedge clock); #1 shuffle = 1'b0;
    @(negedge clock);
    chk("abort_no_valid", int'(card_valid), 0);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clock); @(negedge clock);
      if (card_valid[0]) lat = n;
    end
    chk("regrant_lat", lat, 2);
    chk("regrant_left", int'(cards_left), 39);

    // Reset during SEARCH clears everything including the pending request
    serve(2'b01, 0, lat, val);
    draw = 2'b01;
    @(posedge clock); #1 draw = 2'b00;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_card", int'(card_out), 0);
    chk("midrst_valid", int'(card_valid), 0);
    chk("midrst_left", int'(cards_left), 40);
    chk("midrst_empty", int'(deck_empty), 0);
    cnt = 0;
    repeat (20) begin @(negedge clock); cnt += int'(card_valid != 0); end
    chk("midrst_no_valid", cnt, 0);

    // Held draw yields exactly one card
    cnt = 0;
    draw = 2'b10;
    repeat (100) begin @(negedge clock); cnt += int'(card_valid[1]); end
    draw = 2'b00;
    repeat (15) begin @(negedge clock); cnt += int'(card_valid[1]); end
    chk("held_draw_pulses", cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/card_shoe.md
# card_shoe

Parametrised multi-channel card dealer for the BlackJack datapath, successor to the single-value 1–10 draw counter. A free-running rank counter supplies timing-based randomness. A finite shoe tracks remaining copies of each rank, so no rank is dealt more than COPIES times between shuffles. Draw requests from NUM_CH hands (player, dealer, …) are arbitrated round-robin, and each is answered with a one-cycle valid pulse on that channel.

## Interface
- NUM_CH, 2, number of draw channels
- CARD_MAX, 10, highest rank; ranks are 1..CARD_MAX
- COPIES, 4, copies of each rank per shuffled shoe
- CARD_W, 5, width of one card value
- clock  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high reset
- draw  in  NUM_CH  per-channel draw request; rising edge = one request
- shuffle  in  1  synchronous pulse; refill the shoe
- card_out  out  NUM_CH*CARD_W  channel i card at [i*CARD_W +: CARD_W]; holds last dealt value
- card_valid  out  NUM_CH  one-cycle pulse when channel i's card_out updates
- cards_left  out  $clog2(CARD_MAX*COPIES+1)  cards remaining in the shoe
- deck_empty  out  1  high while cards_left == 0

## Operation
- Rank counter: runs 1..CARD_MAX and advances every cycle; CARD_MAX wraps to 1.
- Remaining table: CARD_MAX entries, each $clog2(COPIES+1) bits; all entries = COPIES after reset or shuffle.
- Edge detect: draw is registered. pending[i] sets on draw[i] & ~draw_q[i].
  - Holding draw high yields exactly one request.
  - A second edge while pending[i] is set is dropped (at most one outstanding per channel).
- FSM states: IDLE, SEARCH.
- IDLE:
  - If any pending bit is set, grant the first pending channel at or after rr_ptr, wrapping.
  - Set cand = current rank counter value and go to SEARCH.
  - Set rr_ptr = granted+1 (mod NUM_CH).
- SEARCH, deck empty:
  - card_out[g] = 0, card_valid[g] pulses, pending[g] clears, go to IDLE.
- SEARCH, remaining[cand] > 0:
  - Decrement remaining[cand] and cards_left.
  - card_out[g] = cand, card_valid[g] pulses, pending[g] clears, go to IDLE.
- SEARCH, remaining[cand] == 0:
  - cand = (cand==CARD_MAX) ? 1 : cand+1; stay in SEARCH.
- Simultaneous events:
  - A new edge on channel g in the same cycle pending[g] clears leaves pending[g] set (set wins).
  - Shuffle has priority over everything except reset.
  - Shuffle refills the table, sets cards_left = CARD_MAX*COPIES and forces IDLE.
  - A grant in progress is abandoned. Its pending bit stays set, it is re-granted, and no valid is issued for the aborted search.
- Reset values:
  - card_out all 0, card_valid 0, cards_left = CARD_MAX*COPIES, deck_empty 0.
  - Rank counter = 1, rr_ptr = 0, pending 0, draw_q 0, FSM IDLE.

## Timing
- Edge k: draw[i] sampled high with draw_q[i] low → pending[i] set.
- Edge k+1: IDLE grant, cand captured from the rank counter.
- Edge k+2+s: card registered and card_valid high for one cycle, where s = number of exhausted ranks skipped (0..CARD_MAX-1).
- Minimum latency is 3 edges from the draw edge; worst case is 2+CARD_MAX edges.
- One grant at a time. The FSM returns to IDLE for one cycle between grants, so back-to-back channels deliver at least 2 cycles apart.
- cards_left and deck_empty update on the same edge as card_valid.
- Shuffle and reset take effect on the next edge.

## Test plan
- Reset, then pulse draw[0] timed so cand captures 7 → card_out[4:0]=7, card_valid=2'b01 for one cycle at edge k+2, cards_left 40→39.
- Draw rank 3 five times, each timed to capture 3:
  - Draws 1–4 return 3.
  - Draw 5 returns 4 with valid one cycle later than normal.
  - remaining[3]=0.
- draw=2'b11 in one cycle from reset:
  - ch0 is served first, ch1 two cycles later.
  - Repeat draw=2'b11 → ch1 is served first (round-robin).
- Draw 40 cards:
  - Each rank is seen exactly 4 times and deck_empty rises with the 40th valid.
  - The 41st draw returns card 0 with valid.
  - A shuffle pulse then gives cards_left=40 and deck_empty=0.
- Shuffle asserted in a SEARCH cycle:
  - No valid is issued in that cycle and the FSM goes to IDLE.
  - The request is re-granted and delivers a card with cards_left=39.
  - Reset asserted mid-SEARCH instead → all outputs at reset values and pending cleared.
- Hold draw[1] high for 100 cycles → exactly one card_valid[1] pulse.
